// File: rtl/menu_controller.sv
// menu_controller: startup menu sequencer (button conditioning, mode select, confirm delay, game hand-off).
// Define MENU_BLINK_EN to make the selected mode string blink while in MENU.
module menu_controller #(
  parameter int   DEBOUNCE_FRAMES = 3,
  parameter int   BLINK_FRAMES    = 16,
  parameter int   CONFIRM_FRAMES  = 60,
  parameter logic DEFAULT_MODE    = 1'b0
) (
  input  logic clk_0,
  input  logic rst,
  input  logic frame_tick,
  input  logic btn_up,
  input  logic btn_down,
  input  logic btn_sel,
  input  logic game_over,
  output logic show_menu,
  output logic hl_sp,
  output logic hl_mp,
  output logic game_start,
  output logic game_mode
);
  localparam logic [3:0] DEB = 4'(DEBOUNCE_FRAMES);
  localparam logic [7:0] CFM = 8'(CONFIRM_FRAMES);
  typedef enum logic [1:0] {MENU, CONFIRM, RUN} state_t;
  state_t st, st_d;
  logic [2:0] raw, s1, s2, stb, stb_q, prs;
  logic [3:0] dcnt [3];
  logic [7:0] ccnt, ccnt_d;
  logic mode, mode_d, cur_menu, cur_d, show_d, hs_d, hm_d, gs_d, gm_d;
  assign raw = {btn_sel, btn_down, btn_up};
  assign prs = stb & ~stb_q;
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
      stb <= '0;
      stb_q <= '0;
      for (int i = 0; i < 3; i++) dcnt[i] <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      stb_q <= stb;
      for (int i = 0; i < 3; i++)
        if (frame_tick) begin
          if (s2[i] == stb[i]) dcnt[i] <= '0;
          else if (dcnt[i] + 4'd1 == DEB) begin
            stb[i] <= s2[i];
            dcnt[i] <= '0;
          end else dcnt[i] <= dcnt[i] + 4'd1;
        end
    end
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) begin
      st <= MENU;
      mode <= DEFAULT_MODE;
      ccnt <= '0;
    end else begin
      st <= st_d;
      mode <= mode_d;
      ccnt <= ccnt_d;
    end
  always_comb begin
    st_d = st;
    mode_d = mode;
    ccnt_d = '0;
    if (st == MENU) begin
      if (prs[2]) st_d = CONFIRM;
      else if (prs[0] ^ prs[1]) mode_d = prs[1];
    end else if (st == CONFIRM) begin
      ccnt_d = frame_tick ? ccnt + 8'd1 : ccnt;
      if (frame_tick && ccnt + 8'd1 == CFM) begin
        st_d = RUN;
        ccnt_d = '0;
      end
    end else if (game_over) st_d = MENU;
  end
`ifdef MENU_BLINK_EN
  localparam logic [5:0] BLK = 6'(BLINK_FRAMES);
  logic [5:0] bcnt, bcnt_d;
  logic ph, ph_d;
  always_comb begin
    bcnt_d = bcnt;
    ph_d = ph;
    if (st == MENU && frame_tick) begin
      bcnt_d = (bcnt + 6'd1 == BLK) ? '0 : bcnt + 6'd1;
      ph_d = (bcnt + 6'd1 == BLK) ? ~ph : ph;
    end
    // Restart with the cursor lit so a new selection is visible at once.
    if ((st_d == MENU && st != MENU) || mode_d != mode) begin
      bcnt_d = '0;
      ph_d = 1'b1;
    end
  end
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) begin
      bcnt <= '0;
      ph <= 1'b1;
    end else begin
      bcnt <= bcnt_d;
      ph <= ph_d;
    end
  assign cur_menu = ph_d;
`else
  assign cur_menu = BLINK_FRAMES != 0;
`endif
  always_comb begin
    cur_d = (st_d == CONFIRM) ? 1'b1 : cur_menu;
    show_d = st_d != RUN;
    hs_d = show_d & ~mode_d & cur_d;
    hm_d = show_d & mode_d & cur_d;
    gs_d = st == CONFIRM && st_d == RUN;
    gm_d = (st == MENU && prs[2]) ? mode : game_mode;
  end
  always_ff @(posedge clk_0 or negedge rst)
    if (!rst) begin
      show_menu <= 1'b1;
      hl_sp <= ~DEFAULT_MODE;
      hl_mp <= DEFAULT_MODE;
      game_start <= 1'b0;
      game_mode <= DEFAULT_MODE;
    end else begin
      show_menu <= show_d;
      hl_sp <= hs_d;
      hl_mp <= hm_d;
      game_start <= gs_d;
      game_mode <= gm_d;
    end
endmodule

// File: doc/menu_controller.md
# menu_controller

Sequencer for the startup menu text overlay. It takes the player's up, down and select buttons, tracks which mode (SINGLEPLAYER or MULTIPLAYER) is chosen, drives the highlight enables for the two mode strings, and hands off to the game with a start pulse and a latched mode. It sits between the button pins and the startup text renderer and game core, and is clocked on the pixel clock domain.

## Interface
- DEBOUNCE_FRAMES, 3: consecutive frame ticks a raw button level must hold before it is accepted (1..15).
- BLINK_FRAMES, 16: frame ticks per cursor blink half-period (1..63).
- CONFIRM_FRAMES, 60: frame ticks spent in CONFIRM before the game starts (1..255).
- DEFAULT_MODE, 0: mode selected after reset (0 = singleplayer, 1 = multiplayer).
- clk_0, input, 1: pixel clock. All state is on the rising edge.
- rst, input, 1: asynchronous, active-low reset.
- frame_tick, input, 1: one-cycle pulse, once per video frame.
- btn_up, input, 1: raw, asynchronous button, active-high.
- btn_down, input, 1: raw, asynchronous button, active-high.
- btn_sel, input, 1: raw, asynchronous button, active-high.
- game_over, input, 1: one-cycle pulse from the game core.
- show_menu, output, 1: enables the startup text overlay.
- hl_sp, output, 1: highlight enable for the SINGLEPLAYER string.
- hl_mp, output, 1: highlight enable for the MULTIPLAYER string.
- game_start, output, 1: one-cycle start pulse.
- game_mode, output, 1: latched mode, held while the game runs.

## Operation
- **Input conditioning.** Each button passes through a 2-flop synchronizer, then a per-button debouncer.
  - The debouncer keeps a stable level and a 4-bit counter.
  - On frame_tick: if the synced level differs from the stable level, the counter increments. Otherwise it clears.
  - When the counter reaches DEBOUNCE_FRAMES, the stable level takes the synced level and the counter clears.
  - A press is a one-cycle pulse on the 0->1 edge of the stable level.
- **FSM states:** MENU, CONFIRM, RUN. Reset state is MENU.
  - **MENU:**
    - up press sets mode to 0; down press sets mode to 1. Both saturate, with no wrap.
    - up and down pressed in the same cycle: both are ignored.
    - sel press moves to CONFIRM and latches game_mode <= mode. sel beats up/down in the same cycle, and the mode latched is the pre-update value.
    - game_over is ignored.
  - **CONFIRM:**
    - A frame counter counts frame_tick. When the count reaches CONFIRM_FRAMES, go to RUN and pulse game_start for 1 cycle.
    - All presses are ignored.
    - game_over is ignored.
  - **RUN:**
    - All presses are ignored.
    - game_over returns to MENU. mode is retained, not reset to DEFAULT_MODE.
- **Outputs:**
  - show_menu = 1 in MENU and CONFIRM.
  - hl_sp = show_menu & (mode==0) & cursor_on.
  - hl_mp = show_menu & (mode==1) & cursor_on.
  - cursor_on = 1 in CONFIRM. In MENU it follows the blink phase; see Configuration.
- **Blink.** A 6-bit counter counts frame_tick in MENU. At BLINK_FRAMES it wraps to 0 and toggles the phase.
  - Counter cleared to 0 and phase set to 1 on entry to MENU and on every mode change, so the cursor is visible immediately.
- **Counter widths.** Counters never exceed their parameter and need no overflow handling beyond the wrap/clear above.

## Timing
- **Reset values:**
  - show_menu = 1, hl_sp = (DEFAULT_MODE==0), hl_mp = (DEFAULT_MODE==1).
  - game_start = 0, game_mode = DEFAULT_MODE.
  - mode = DEFAULT_MODE, blink phase = 1.
  - All counters 0, all debouncer stable levels 0, all synchronizer flops 0.
- **Latency.** All outputs are registered.
  - Raw button edge to stable-level change: 2 cycles plus DEBOUNCE_FRAMES frame ticks.
  - Press pulse to mode/state change: 1 cycle. hl_* updates on the same edge as mode.
  - game_start asserts on the same edge that the state becomes RUN. show_menu falls on that same edge.
- **frame_tick coincident with a state change.** It is consumed by the old state's counter. The new state's counters start from 0.
- **Reset mid-operation** (rst low in any state) forces the reset values immediately. No game_start is emitted across reset.
- **A button held across the MENU return** does not produce a new press. Only a fresh 0->1 edge of the stable level counts.

## Configuration
- `MENU_BLINK_EN` defined: cursor_on in MENU equals the blink phase. The selected string flashes with a half-period of BLINK_FRAMES frames.
- `MENU_BLINK_EN` undefined: cursor_on = 1 in MENU (steady highlight), and the blink counter and phase are not built.
  - hl_* then change only on mode or state change.

## Test plan
- **Reset:** hold rst=0 for 5 cycles, then release. Expect show_menu=1, hl_sp=1, hl_mp=0, game_start=0, game_mode=0 with DEFAULT_MODE=0.
- **Debounce and mode change:** hold btn_down high for 3 frame ticks (DEBOUNCE_FRAMES=3). Expect mode=1 and hl_mp=1 one cycle after the press pulse. Then glitch btn_up high for 2 ticks only: mode stays 1.
- **Saturation and simultaneous presses:** with mode=1, press down: mode stays 1. Press up and down in the same cycle: mode unchanged.
- **Start sequence:** with mode=1, press sel. Expect CONFIRM with hl_mp=1 steady. After exactly 60 frame ticks, game_start is high for exactly 1 cycle, game_mode=1, show_menu=0.
- **Return to menu:** in RUN, pulse game_over. Expect show_menu=1 the next cycle, mode still 1, and no game_start. sel held throughout produces no press until it is released and pressed again.
- **Blink (with MENU_BLINK_EN, BLINK_FRAMES=16):** hl_sp toggles every 16 frame ticks. After a mode change, the newly selected string's highlight is 1 immediately.
